// File: rtl/fn_input_stage_pkg.sv
// Shared constants and per-operand float helpers for the f(x) input stage.
package fn_input_stage_pkg;

  localparam int FLT_W          = 32;
  localparam int CORDIC_W       = 22;
  localparam int CORDIC_FRAC    = 20;
  localparam int LATENCY_CYCLES = 5;

  // IEEE-754 single field layout
  localparam int SIGN_POS = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int MAN_HI   = 22;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;

  // Q2.20 reference points
  localparam logic [21:0] Q_ONE = 22'h100000;
  localparam logic [21:0] Q_MAX = 22'h1FFFFF;
  localparam logic [21:0] Q_MIN = 22'h200000;

  localparam logic [31:0] F_POS_INF  = 32'h7F800000;
  localparam logic [31:0] F_QNAN     = 32'h7FC00000;
  localparam logic [31:0] F_POS_ZERO = 32'h00000000;

  // (x / 128) - 1.0 in Q2.20, floored, saturated. 'bias' is the exponent at
  // which the 24-bit significand lines up with the Q2.20 integer LSB.
  function automatic logic [21:0] angle_q(input logic [31:0] x, input int bias);
    logic               sgn;
    logic [7:0]         e;
    logic [23:0]        m;
    int                 sh;
    logic [4:0]         rs;
    logic [47:0]        wide;
    logic [25:0]        mag;
    logic               sticky;
    logic               sat;
    logic signed [27:0] v;
    logic signed [27:0] y;
    logic [21:0]        r;
    sgn    = x[SIGN_POS];
    e      = x[EXP_HI:EXP_LO];
    m      = {1'b1, x[MAN_HI:0]};
    sh     = int'(e) - bias;
    rs     = 5'd0;
    wide   = 48'd0;
    mag    = 26'd0;
    sticky = 1'b0;
    sat    = 1'b0;
    if (e == 8'd0) begin
      mag = 26'd0;                      // zero and subnormals read as 0.0
    end else if (sh >= 2) begin
      sat = 1'b1;                       // |x| far beyond the Q2.20 range
    end else if (sh == 1) begin
      mag = {1'b0, m, 1'b0};
    end else if (sh == 0) begin
      mag = {2'b00, m};
    end else begin
      // Shifts past 25 only lose bits into the sticky flag
      rs     = (sh < -25) ? 5'd25 : 5'(-sh);
      wide   = {m, 24'd0} >> rs;
      mag    = {2'b00, wide[47:24]};
      sticky = |wide[23:0];
    end
    // Floor toward -inf: a negative value with lost bits steps one LSB down
    if (sgn) begin
      v = -$signed({2'b00, mag + {25'd0, sticky}});
    end else begin
      v = $signed({2'b00, mag});
    end
    y = v - $signed({6'd0, Q_ONE});
    if (sat) begin
      r = sgn ? Q_MIN : Q_MAX;
    end else if (y > 28'sd2097151) begin
      r = Q_MAX;
    end else if (y < -28'sd2097152) begin
      r = Q_MIN;
    end else begin
      r = y[21:0];
    end
    return r;
  endfunction

  // x / 2 by exponent decrement; tiny values flush to signed zero
  function automatic logic [31:0] half_f(input logic [31:0] x);
    logic [7:0]  e;
    logic [31:0] r;
    e = x[EXP_HI:EXP_LO];
    if (e == 8'hFF) begin
      r = x;
    end else if (e > 8'd1) begin
      r = {x[SIGN_POS], e - 8'd1, x[MAN_HI:0]};
    end else begin
      r = {x[SIGN_POS], F_POS_ZERO[30:0]};
    end
    return r;
  endfunction

  // x * x with round-to-nearest-even; no subnormal results
  function automatic logic [31:0] square_f(input logic [31:0] x);
    logic [7:0]        e;
    logic [23:0]       m;
    logic [47:0]       p;
    logic [22:0]       frac;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [23:0]       rnd;
    logic signed [9:0] be;
    logic [31:0]       r;
    e = x[EXP_HI:EXP_LO];
    m = {1'b1, x[MAN_HI:0]};
    p = {24'd0, m} * {24'd0, m};
    if (p[47]) begin
      frac   = p[46:24];
      guard  = p[23];
      sticky = |p[22:0];
      be     = 10'sd1;
    end else begin
      frac   = p[45:23];
      guard  = p[22];
      sticky = |p[21:0];
      be     = 10'sd0;
    end
    round_up = guard & (sticky | frac[0]);
    rnd      = {1'b0, frac} + {23'd0, round_up};
    be       = be + $signed({1'b0, e, 1'b0}) - 10'sd127 + $signed({9'd0, rnd[23]});
    if (e == 8'hFF) begin
      r = (x[MAN_HI:0] != 23'd0) ? F_QNAN : F_POS_INF;
    end else if (e == 8'd0) begin
      r = F_POS_ZERO;
    end else if (be >= 10'sd255) begin
      r = F_POS_INF;
    end else if (be <= 10'sd0) begin
      r = F_POS_ZERO;
    end else begin
      r = {1'b0, be[7:0], rnd[22:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/fn_input_stage_latency_timer.sv
// Single-operation latency timer: accepts a start while idle, counts enabled
// cycles and issues one done pulse exactly LATENCY enabled edges later.
module fn_input_stage_latency_timer #(
  parameter int LATENCY = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic start,
  output logic working,
  output logic done,
  output logic accept,
  output logic fire
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY);

  // bit0 = busy, bit1 = done pulse, so the outputs come straight off flops
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b11;

  logic [1:0]    state_r;
  logic [CW-1:0] cnt_r;

  assign working = state_r[0];
  assign done    = state_r[1];
  assign accept  = clk_en & start & (state_r == ST_IDLE);
  assign fire    = clk_en & (state_r == ST_RUN) & (cnt_r == CNT_LAST);

  // Advance idle -> run -> done -> idle only on enabled cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CW'(0);
    end else if (clk_en) begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_RUN;
            cnt_r   <= CW'(1);
          end
        end
        ST_RUN: begin
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          cnt_r   <= CW'(0);
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CW'(0);
        end
      endcase
    end
  end

endmodule

// File: rtl/fn_input_stage.sv
// Input stage of the f(x) evaluator: latches an operand pair, and after a fixed
// latency publishes the CORDIC angle, x/2 and x^2 for each operand.
module fn_input_stage
  import fn_input_stage_pkg::*;
#(
  parameter int FLT_DATA_WIDTH    = FLT_W,
  parameter int CORDIC_DATA_WIDTH = CORDIC_W,
  parameter int CORDIC_FRAC_BITS  = CORDIC_FRAC,
  parameter int LATENCY           = LATENCY_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         start,
  input  logic [FLT_DATA_WIDTH-1:0]    x_one,
  input  logic [FLT_DATA_WIDTH-1:0]    x_two,
  output logic                         done,
  output logic                         working,
  output logic [CORDIC_DATA_WIDTH-1:0] out_one,
  output logic [CORDIC_DATA_WIDTH-1:0] out_two,
  output logic [FLT_DATA_WIDTH-1:0]    half_out_one,
  output logic [FLT_DATA_WIDTH-1:0]    half_out_two,
  output logic [FLT_DATA_WIDTH-1:0]    square_out_one,
  output logic [FLT_DATA_WIDTH-1:0]    square_out_two
);

  // Exponent that maps the significand LSB onto the Q2.20 LSB after /128
  localparam int ANGLE_BIAS = EXP_BIAS + 7 + MAN_W - CORDIC_FRAC_BITS;

  logic                         accept_s;
  logic                         fire_s;
  logic [FLT_DATA_WIDTH-1:0]    x_one_r;
  logic [FLT_DATA_WIDTH-1:0]    x_two_r;
  logic [CORDIC_DATA_WIDTH-1:0] angle_one_s;
  logic [CORDIC_DATA_WIDTH-1:0] angle_two_s;
  logic [FLT_DATA_WIDTH-1:0]    half_one_s;
  logic [FLT_DATA_WIDTH-1:0]    half_two_s;
  logic [FLT_DATA_WIDTH-1:0]    square_one_s;
  logic [FLT_DATA_WIDTH-1:0]    square_two_s;

  fn_input_stage_latency_timer #(
    .LATENCY (LATENCY)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .start   (start),
    .working (working),
    .done    (done),
    .accept  (accept_s),
    .fire    (fire_s)
  );

  // Hold the accepted operand pair for the whole operation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_one_r <= {FLT_DATA_WIDTH{1'b0}};
      x_two_r <= {FLT_DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      x_one_r <= x_one;
      x_two_r <= x_two;
    end
  end

  // Both operand paths are identical and settle well within LATENCY cycles
  assign angle_one_s  = angle_q(x_one_r, ANGLE_BIAS);
  assign angle_two_s  = angle_q(x_two_r, ANGLE_BIAS);
  assign half_one_s   = half_f(x_one_r);
  assign half_two_s   = half_f(x_two_r);
  assign square_one_s = square_f(x_one_r);
  assign square_two_s = square_f(x_two_r);

  // Publish all six results together on the done edge; hold until the next one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_one        <= {CORDIC_DATA_WIDTH{1'b0}};
      out_two        <= {CORDIC_DATA_WIDTH{1'b0}};
      half_out_one   <= {FLT_DATA_WIDTH{1'b0}};
      half_out_two   <= {FLT_DATA_WIDTH{1'b0}};
      square_out_one <= {FLT_DATA_WIDTH{1'b0}};
      square_out_two <= {FLT_DATA_WIDTH{1'b0}};
    end else if (fire_s) begin
      out_one        <= angle_one_s;
      out_two        <= angle_two_s;
      half_out_one   <= half_one_s;
      half_out_two   <= half_two_s;
      square_out_one <= square_one_s;
      square_out_two <= square_two_s;
    end
  end

endmodule

// File: tb/tb_fn_input_stage.sv
// Self-checking bench for fn_input_stage: hand-derived vectors, expected
// results queued at start and compared when done fires.
`timescale 1ns/1ps
module tb_fn_input_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x_one = 32'd0;
  logic [31:0] x_two = 32'd0;
  logic        done;
  logic        working;
  logic [21:0] out_one, out_two;
  logic [31:0] half_out_one, half_out_two, square_out_one, square_out_two;

  fn_input_stage dut (
    .clk            (clk),
    .rst            (rst),
    .clk_en         (clk_en),
    .start          (start),
    .x_one          (x_one),
    .x_two          (x_two),
    .done           (done),
    .working        (working),
    .out_one        (out_one),
    .out_two        (out_two),
    .half_out_one   (half_out_one),
    .half_out_two   (half_out_two),
    .square_out_one (square_out_one),
    .square_out_two (square_out_two)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [21:0] a1;
    logic [31:0] h1;
    logic [31:0] s1;
    logic [21:0] a2;
    logic [31:0] h2;
    logic [31:0] s2;
  } res_t;

  res_t got;
  assign got = {out_one, half_out_one, square_out_one, out_two, half_out_two, square_out_two};

  res_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // operand, angle (x-128)/128, x/2, x*x -- worked out by hand
  localparam int NV = 16;
  localparam logic [31:0] X_TAB [NV] = '{
    32'h43000000, 32'h43400000, 32'h3F800000, 32'h00000000,
    32'h7149F2CA, 32'hBF800000, 32'h7FC00000, 32'hC3800000,
    32'h43BF8000, 32'h43C00000, 32'h00000001, 32'h8D800000,
    32'h80800000, 32'h3FFFFFFF, 32'h3F800800, 32'h3F800801};
  localparam logic [21:0] A_TAB [NV] = '{
    22'h000000, 22'h080000, 22'h302000, 22'h300000,
    22'h1FFFFF, 22'h2FE000, 22'h1FFFFF, 22'h200000,
    22'h1FE000, 22'h1FFFFF, 22'h300000, 22'h2FFFFF,
    22'h2FFFFF, 22'h303FFF, 22'h302002, 22'h302002};
  localparam logic [31:0] H_TAB [NV] = '{
    32'h42800000, 32'h42C00000, 32'h3F000000, 32'h00000000,
    32'h70C9F2CA, 32'hBF000000, 32'h7FC00000, 32'hC3000000,
    32'h433F8000, 32'h43400000, 32'h00000000, 32'h8D000000,
    32'h80000000, 32'h3F7FFFFF, 32'h3F000800, 32'h3F000801};
  localparam logic [31:0] S_TAB [NV] = '{
    32'h46800000, 32'h47100000, 32'h3F800000, 32'h00000000,
    32'h7F800000, 32'h3F800000, 32'h7FC00000, 32'h47800000,
    32'h480F4040, 32'h48100000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h407FFFFE, 32'h3F801000, 32'h3F801003};

  function automatic res_t expect_pair(input int i, input int j);
    res_t r;
    r.a1 = A_TAB[i]; r.h1 = H_TAB[i]; r.s1 = S_TAB[i];
    r.a2 = A_TAB[j]; r.h2 = H_TAB[j]; r.s2 = S_TAB[j];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one enabled edge and queue the expected result
  task automatic issue(input int i, input int j);
    x_one  = X_TAB[i];
    x_two  = X_TAB[j];
    clk_en = 1'b1;
    start  = 1'b1;
    sb_q.push_back(expect_pair(i, j));
    tick();
    start = 1'b0;
  endtask

  // Count cycles to done, optionally stalling or re-poking start mid-operation
  task automatic wait_done(input int stall_at, input int stall_len, input bit poke,
                           output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int k = 0; k < 60; k++) begin
      clk_en = (lat >= stall_at && lat < stall_at + stall_len) ? 1'b0 : 1'b1;
      if (poke && lat == 2) begin
        x_one = X_TAB[4];
        x_two = X_TAB[5];
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    clk_en = 1'b1;
    start  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; clk_en = 1'b1; start = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (got !== 180'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", got);
    end
    n_vec++;
    if (working !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: working=%b done=%b want 0 0", working, done);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_spec_vectors();
    int   lat;
    bit   ok;
    res_t exp_r;
    int   pa[3] = '{0, 1, 3};
    int   pb[3] = '{0, 2, 4};
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (working !== 1'b0) begin
        n_err++; $display("FAIL idle_working[%0d]: got %b want 0", k, working);
      end
      issue(pa[k], pb[k]);
      n_vec++;
      if (working !== 1'b1) begin
        n_err++; $display("FAIL busy_working[%0d]: got %b want 1", k, working);
      end
      wait_done(99, 0, 1'b0, lat, ok);
      exp_r = sb_q.pop_front();
      n_vec++;
      if (!ok || lat != 5) begin
        n_err++; $display("FAIL spec_latency[%0d]: got %0d (seen=%b) want 5", k, lat, ok);
      end
      n_vec++;
      if (got !== exp_r) begin
        n_err++; $display("FAIL spec_data[%0d]: got %h want %h", k, got, exp_r);
      end
      n_vec++;
      if (working !== 1'b1) begin
        n_err++; $display("FAIL done_cycle_working[%0d]: got %b want 1", k, working);
      end
      tick();
      n_vec++;
      if (done !== 1'b0 || working !== 1'b0) begin
        n_err++; $display("FAIL after_done[%0d]: done=%b working=%b want 0 0", k, done, working);
      end
    end
  endtask

  task automatic test_table();
    int   lat;
    bit   ok;
    res_t exp_r;
    for (int i = 0; i < NV; i++) begin
      issue(i, NV - 1 - i);
      wait_done(99, 0, 1'b0, lat, ok);
      exp_r = sb_q.pop_front();
      n_vec++;
      if (!ok || lat != 5) begin
        n_err++; $display("FAIL table_latency[%0d]: got %0d (seen=%b) want 5", i, lat, ok);
      end
      n_vec++;
      if (got !== exp_r) begin
        n_err++; $display("FAIL table_data[%0d]: got %h want %h", i, got, exp_r);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int   lat;
    bit   ok;
    res_t exp_r;
    issue(8, 9);
    wait_done(2, 3, 1'b0, lat, ok);
    exp_r = sb_q.pop_front();
    n_vec++;
    if (!ok || lat != 8) begin
      n_err++; $display("FAIL stall_latency: got %0d (seen=%b) want 8", lat, ok);
    end
    n_vec++;
    if (got !== exp_r) begin
      n_err++; $display("FAIL stall_data: got %h want %h", got, exp_r);
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int   lat;
    bit   ok;
    res_t exp_r;
    issue(13, 14);
    wait_done(99, 0, 1'b1, lat, ok);
    exp_r = sb_q.pop_front();
    n_vec++;
    if (!ok || lat != 5) begin
      n_err++; $display("FAIL ignore_latency: got %0d (seen=%b) want 5", lat, ok);
    end
    n_vec++;
    if (got !== exp_r) begin
      n_err++; $display("FAIL ignore_data: got %h want %h", got, exp_r);
    end
    tick();
    repeat (6) tick();
    n_vec++;
    if (working !== 1'b0) begin
      n_err++; $display("FAIL ignore_no_restart: working=%b want 0", working);
    end
  endtask

  task automatic test_reset_abort();
    int   lat;
    bit   ok;
    int   seen;
    res_t exp_r;
    issue(6, 7);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    exp_r = sb_q.pop_front();
    n_vec++;
    if (got !== 180'd0 || working !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL abort_clear: got %h working=%b done=%b want 0", got, working, done);
    end
    tick();
    rst  = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++; $display("FAIL abort_no_done: got %0d pulses want 0 (dropped %h)", seen, exp_r);
    end
    issue(10, 11);
    wait_done(99, 0, 1'b0, lat, ok);
    exp_r = sb_q.pop_front();
    n_vec++;
    if (!ok || lat != 5 || got !== exp_r) begin
      n_err++; $display("FAIL abort_recover: lat=%0d got %h want 5 %h", lat, got, exp_r);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int   lat;
    bit   ok;
    res_t exp_r;
    res_t first_r;
    issue(2, 5);
    wait_done(99, 0, 1'b0, lat, ok);
    first_r = sb_q.pop_front();
    n_vec++;
    if (!ok || got !== first_r) begin
      n_err++; $display("FAIL b2b_first: got %h want %h", got, first_r);
    end
    tick();
    issue(7, 12);
    n_vec++;
    if (working !== 1'b1) begin
      n_err++; $display("FAIL b2b_accept: working=%b want 1", working);
    end
    n_vec++;
    if (got !== first_r) begin
      n_err++; $display("FAIL b2b_hold: got %h want %h", got, first_r);
    end
    wait_done(99, 0, 1'b0, lat, ok);
    exp_r = sb_q.pop_front();
    n_vec++;
    if (!ok || lat != 5) begin
      n_err++; $display("FAIL b2b_latency: got %0d (seen=%b) want 5", lat, ok);
    end
    n_vec++;
    if (got !== exp_r) begin
      n_err++; $display("FAIL b2b_data: got %h want %h", got, exp_r);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_table();
    test_stall();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
